// File: rtl/lora_tx_pack_pkg.sv
// Shared constants, FSM encoding and checksum helper for the LoRa transmit packer.
package lora_tx_pack_pkg;
   localparam int         BCD_DIGITS = 4;
   localparam logic [7:0] HDR_DEF    = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CONV = 3'd1,
      S_HDR  = 3'd2,
      S_HI   = 3'd3,
      S_LO   = 3'd4,
      S_CHK  = 3'd5
   } state_t;

   function automatic logic [7:0] frame_chk(input logic [7:0] h, input logic [7:0] hi,
                                            input logic [7:0] lo);
      return h + hi + lo;
   endfunction
endpackage

// File: rtl/lora_tx_pack_if.sv
// Byte stream towards the LoRa UART transmitter (valid/ready).
interface lora_tx_pack_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/lora_tx_pack_bcd2bin.sv
// Iterative BCD to binary converter: one digit per cycle, most significant first.
module lora_tx_pack_bcd2bin
   import lora_tx_pack_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [4*BCD_DIGITS-1:0] bcd,
   output logic                    done,
   output logic                    err,
   output logic [15:0]             result
);
   localparam int CW = $clog2(BCD_DIGITS);

   logic [4*BCD_DIGITS-1:0] dig_sr;
   logic [15:0]             acc;
   logic [CW-1:0]           cnt;
   logic                    active;
   logic                    bad;
   logic [3:0]              digit;
   logic                    bad_nxt;

   assign digit   = dig_sr[4*BCD_DIGITS-1 -: 4];
   assign bad_nxt = bad | (digit > 4'd9);
   assign result  = acc;

   // done/err are single-cycle pulses raised on the last digit step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_sr <= '0;
         acc    <= '0;
         cnt    <= '0;
         active <= 1'b0;
         bad    <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (start) begin
            dig_sr <= bcd;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b1;
            bad    <= 1'b0;
         end else if (active) begin
            acc    <= (acc << 3) + (acc << 1) + {12'd0, digit};
            dig_sr <= dig_sr << 4;
            bad    <= bad_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(BCD_DIGITS-1)) begin
               active <= 1'b0;
               done   <= ~bad_nxt;
               err    <= bad_nxt;
            end
         end
      end
   end
endmodule

// File: rtl/lora_tx_pack.sv
// BCD value to framed byte stream (HDR, HI, LO[, CHK]) sent periodically or on request.
// Define LORA_TX_CHK_EN to append the checksum byte (HDR+HI+LO mod 256).
module lora_tx_pack
   import lora_tx_pack_pkg::*;
#(
   parameter int         PERIOD = 50_000_000,
   parameter logic [7:0] HDR    = HDR_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           bcd_in,
   input  logic                  send_req,
   lora_tx_pack_if.master        tx,
   output logic                  busy,
   output logic [15:0]           value,
   output logic                  err
);
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   state_t        state, state_nxt;
   logic [PW-1:0] per_cnt;
   logic          tick, trigger, start, accept;
   logic          conv_done;
   logic [15:0]   conv_result;

   assign tick    = (per_cnt == PW'(PERIOD-1));
   assign trigger = tick | send_req;
   assign start   = (state == S_IDLE) && trigger;
   assign accept  = tx.tx_valid && tx.tx_ready;

   // free-running frame timer, independent of frame progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    per_cnt <= '0;
      else if (tick) per_cnt <= '0;
      else           per_cnt <= per_cnt + 1'b1;
   end

   lora_tx_pack_bcd2bin u_conv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bcd    (bcd_in),
      .done   (conv_done),
      .err    (err),
      .result (conv_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (trigger)   state_nxt = S_CONV;
         S_CONV: if (err)       state_nxt = S_IDLE;
                 else if (conv_done) state_nxt = S_HDR;
         S_HDR:  if (accept)    state_nxt = S_HI;
         S_HI:   if (accept)    state_nxt = S_LO;
`ifdef LORA_TX_CHK_EN
         S_LO:   if (accept)    state_nxt = S_CHK;
         S_CHK:  if (accept)    state_nxt = S_IDLE;
`else
         S_LO:   if (accept)    state_nxt = S_IDLE;
`endif
         default:               state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != S_IDLE);
      tx.tx_valid = 1'b0;
      tx.tx_data  = 8'h00;
      case (state)
         S_HDR: begin tx.tx_valid = 1'b1; tx.tx_data = HDR;         end
         S_HI:  begin tx.tx_valid = 1'b1; tx.tx_data = value[15:8]; end
         S_LO:  begin tx.tx_valid = 1'b1; tx.tx_data = value[7:0];  end
`ifdef LORA_TX_CHK_EN
         S_CHK: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = frame_chk(HDR, value[15:8], value[7:0]);
         end
`endif
         default: ;
      endcase
   end

   // value only moves on a good conversion, so bytes stay stable through the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            value <= '0;
      else if (state == S_CONV && conv_done) value <= conv_result;
   end
endmodule

// File: tb/tb_lora_tx_pack.sv
// Scoreboard bench for lora_tx_pack (PERIOD=16); honours LORA_TX_CHK_EN.
module tb_lora_tx_pack;
   localparam int PERIOD = 16;
`ifdef LORA_TX_CHK_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, send_req = 1'b0;
   logic [15:0] bcd_in = 16'h0000;
   logic        busy, err;
   logic [15:0] value;

   lora_tx_pack_if bus();

   lora_tx_pack #(.PERIOD(PERIOD), .HDR(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .send_req(send_req),
      .tx(bus), .busy(busy), .value(value), .err(err)
   );

   always #5 clk = ~clk;

   int n_assert = 0, n_fail = 0;
   logic [7:0] exp_q[$];

   // reference model state: conversion countdown, bytes left, last good value
   int          mcnt = 0, mconv = 0, mleft = 0;
   logic        minv = 1'b0;
   logic [15:0] msnap = 16'h0, mvalue = 16'h0;

   function automatic logic [16:0] ref_conv(input logic [15:0] b);
      int   v;
      logic inv;
      v   = 0;
      inv = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (b[4*i +: 4] > 4'd9) inv = 1'b1;
         v = v * 10 + int'(b[4*i +: 4]);
      end
      return {inv, v[15:0]};
   endfunction

   wire [16:0] mref  = ref_conv(bcd_in);
   wire        mtrig = (mcnt == PERIOD-1) || send_req;
   wire        mbusy = (mconv != 0) || (mleft != 0);
   wire [7:0]  mchk  = 8'hA5 + mref[15:8] + mref[7:0];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt <= 0; mconv <= 0; mleft <= 0; minv <= 1'b0; mvalue <= 16'h0;
         exp_q.delete();
      end else begin
         mcnt <= (mcnt == PERIOD-1) ? 0 : mcnt + 1;
         if (!mbusy) begin
            if (mtrig) begin
               minv  <= mref[16];
               msnap <= mref[15:0];
               mconv <= 5;
               if (!mref[16]) begin
                  exp_q.push_back(8'hA5);
                  exp_q.push_back(mref[15:8]);
                  exp_q.push_back(mref[7:0]);
                  if (NB == 4) exp_q.push_back(mchk);
               end
            end
         end else if (mconv != 0) begin
            mconv <= mconv - 1;
            if (mconv == 1 && !minv) begin
               mleft  <= NB;
               mvalue <= msnap;
            end
         end else if (bus.tx_ready) begin
            mleft <= mleft - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", busy, mbusy);
         check("tx_valid", bus.tx_valid, mleft != 0);
         check("err", err, (mconv == 1) && minv);
         check("value", value, mvalue);
         if (bus.tx_valid && bus.tx_ready) begin
            check("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_byte", bus.tx_data, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pulse();
      send_req = 1'b1;
      step();
      send_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (mbusy && n < 200) begin step(); n++; end
      check("idle_timeout", n < 200, 1);
   endtask

   task automatic wait_hi();
      int n = 0;
      while (mleft != NB-1 && n < 100) begin step(); n++; end
      check("hi_timeout", n < 100, 1);
   endtask

   initial begin
      int errs, vlds, frames;
      logic prev, sent;
      bus.tx_ready = 1'b1;
      #1;
      check("rst_tx_data", bus.tx_data, 8'h00);
      check("rst_tx_valid", bus.tx_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_value", value, 16'h0);
      check("rst_err", err, 1'b0);
      step();
      rst_n = 1'b1;

      // 0123 -> 0x007B
      bcd_in = 16'h0123; wait_idle(); pulse(); wait_idle();
      check("t1_value", value, 16'h007B);
      check("t1_busy", busy, 1'b0);

      // 9999 -> 0x270F, input changes after snapshot are ignored
      bcd_in = 16'h9999; wait_idle(); pulse();
      step(); step(); bcd_in = 16'h0000;
      wait_idle();
      check("t2_value", value, 16'h270F);

      // backpressure on HI byte
      bcd_in = 16'h0500; wait_idle(); pulse(); wait_hi();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_data", bus.tx_data, 8'h01);
         check("t3_hold_valid", bus.tx_valid, 1'b1);
      end
      step();
      bus.tx_ready = 1'b1;
      wait_idle();
      check("t3_value", value, 16'h01F4);

      // invalid digit: single err pulse, no bytes, value kept
      bcd_in = 16'h12A4; wait_idle(); pulse();
      errs = 0; vlds = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         errs += int'(err);
         vlds += int'(bus.tx_valid);
      end
      check("t4_err_pulses", errs, 1);
      check("t4_no_valid", vlds, 0);
      wait_idle();
      check("t4_value", value, 16'h01F4);

      // periodic frames; send_req while busy is dropped
      bcd_in = 16'h0042; wait_idle();
      frames = 0; sent = 1'b0; prev = bus.tx_valid;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         if (bus.tx_valid && !prev) frames++;
         prev = bus.tx_valid;
         step();
         send_req = mbusy && (mleft != 0) && !sent;
         if (send_req) sent = 1'b1;
      end
      send_req = 1'b0;
      check("t5_frames", frames, 3);
      check("t5_req_sent", sent, 1'b1);

      // reset mid-frame
      bcd_in = 16'h0777; wait_idle(); pulse(); wait_hi();
      #2 rst_n = 1'b0;
      #1;
      check("t6_tx_data", bus.tx_data, 8'h00);
      check("t6_tx_valid", bus.tx_valid, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_value", value, 16'h0);
      check("t6_err", err, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      begin
         int n = 0;
         while (!bus.tx_valid && n < 40) begin step(); n++; end
      end
      check("t6_restart_valid", bus.tx_valid, 1'b1);
      check("t6_restart_hdr", bus.tx_data, 8'hA5);
      wait_idle();
      check("t6_value_after", value, 16'h0309);

      wait_idle();
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
